// File: rtl/sv_pulse_gen6.sv
// Transmit side of the SV transition interface: one clean high pulse per command, then a forced low gap.
// Optional burst repeat is enabled by defining SVGEN_REPEAT_EN (adds cmd_repeat input).
module sv_pulse_gen6 #(
  parameter int WIDTH  = 6,
  parameter int HOLD_W = 8,
  parameter int GUARD  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [WIDTH-1:0]  cmd_mask,
  input  logic [HOLD_W-1:0] cmd_hold,
`ifdef SVGEN_REPEAT_EN
  input  logic [3:0]        cmd_repeat,
`endif
  output logic [WIDTH-1:0]  SV,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_e;

  localparam logic [HOLD_W-1:0] GUARD_M1 = HOLD_W'(GUARD - 1);

  state_e              state_q, state_d;
  logic [WIDTH-1:0]    sv_q, sv_d;
  logic [HOLD_W-1:0]   cnt_q, cnt_d;
  logic                done_q, done_d;
  logic                busy_q, busy_d;
  logic                accept_s;
  logic [HOLD_W-1:0]   hold_m1_s;
`ifdef SVGEN_REPEAT_EN
  logic [WIDTH-1:0]    mask_q, mask_d;
  logic [HOLD_W-1:0]   hold_m1_q, hold_m1_d;
  logic [3:0]          rep_q, rep_d;
`endif

  assign cmd_ready = (state_q == IDLE);
  assign accept_s  = cmd_valid & cmd_ready;
  // A hold of zero behaves like a hold of one.
  assign hold_m1_s = (cmd_hold == '0) ? '0 : (cmd_hold - HOLD_W'(1));

  assign SV   = sv_q;
  assign busy = busy_q;
  assign done = done_q;

  // Next-state and next-output decode for the pulse FSM.
  always_comb begin
    state_d = state_q;
    sv_d    = sv_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
`ifdef SVGEN_REPEAT_EN
    mask_d    = mask_q;
    hold_m1_d = hold_m1_q;
    rep_d     = rep_q;
`endif
    case (state_q)
      IDLE: begin
        if (accept_s) begin
`ifdef SVGEN_REPEAT_EN
          mask_d    = cmd_mask;
          hold_m1_d = hold_m1_s;
          rep_d     = cmd_repeat;
`endif
          if (cmd_mask != '0) begin
            state_d = HIGH;
            sv_d    = cmd_mask;
            cnt_d   = hold_m1_s;
          end else begin
            done_d  = 1'b1;
          end
        end else begin
          state_d = IDLE;
        end
      end
      HIGH: begin
        if (cnt_q == '0) begin
          state_d = LOW;
          sv_d    = '0;
          cnt_d   = GUARD_M1;
        end else begin
          cnt_d   = cnt_q - HOLD_W'(1);
        end
      end
      LOW: begin
        if (cnt_q == '0) begin
`ifdef SVGEN_REPEAT_EN
          if (rep_q != 4'd0) begin
            state_d = HIGH;
            sv_d    = mask_q;
            cnt_d   = hold_m1_q;
            rep_d   = rep_q - 4'd1;
          end else begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
`else
          state_d = IDLE;
          done_d  = 1'b1;
`endif
        end else begin
          cnt_d   = cnt_q - HOLD_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        sv_d    = '0;
        cnt_d   = '0;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and output registers; reset clears SV without waiting for a clock edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      sv_q    <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
`ifdef SVGEN_REPEAT_EN
      mask_q    <= '0;
      hold_m1_q <= '0;
      rep_q     <= 4'd0;
`endif
    end else begin
      state_q <= state_d;
      sv_q    <= sv_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
`ifdef SVGEN_REPEAT_EN
      mask_q    <= mask_d;
      hold_m1_q <= hold_m1_d;
      rep_q     <= rep_d;
`endif
    end
  end

endmodule

// File: tb/tb_sv_pulse_gen6.sv
// Directed, table-driven bench for sv_pulse_gen6 with a rising-edge detector model (ST = SV & ~SV_prev).
// Define SVGEN_REPEAT_EN to also exercise the burst-repeat sequence.
module tb_sv_pulse_gen6;

  logic       clk;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [5:0] cmd_mask;
  logic [7:0] cmd_hold;
`ifdef SVGEN_REPEAT_EN
  logic [3:0] cmd_repeat;
`endif
  logic [5:0] SV;
  logic       busy;
  logic       done;

  sv_pulse_gen6 dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_mask  (cmd_mask),
    .cmd_hold  (cmd_hold),
`ifdef SVGEN_REPEAT_EN
    .cmd_repeat(cmd_repeat),
`endif
    .SV        (SV),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       valid;
    logic [5:0] mask;
    logic [7:0] hold;
    logic [5:0] sv;
    logic [5:0] st;
    logic       done;
    logic       ready;
    logic       busy;
  } vec_t;

  vec_t       vec [0:25];
  int         n_vec;
  int         n_err;
  logic [5:0] sv_prev;
  logic [5:0] st;

  function automatic vec_t mk(logic v, logic [5:0] m, logic [7:0] h, logic [5:0] s,
                              logic [5:0] t, logic d, logic r, logic b);
    vec_t x;
    x.valid = v; x.mask = m; x.hold = h; x.sv = s;
    x.st = t; x.done = d; x.ready = r; x.busy = b;
    return x;
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (sv,st,done,ready,busy)", name, act, exp);
    end
  endtask

  // Sample outputs mid-cycle and update the detector model.
  task automatic sample(input string name, input logic [5:0] e_sv, input logic [5:0] e_st,
                        input logic e_done, input logic e_ready, input logic e_busy);
    st      = SV & ~sv_prev;
    sv_prev = SV;
    check(name, {SV, st, done, cmd_ready, busy}, {e_sv, e_st, e_done, e_ready, e_busy});
  endtask

  initial begin
    n_vec = 0; n_err = 0; sv_prev = 6'd0;
    cmd_valid = 1'b0; cmd_mask = 6'd0; cmd_hold = 8'd0;
`ifdef SVGEN_REPEAT_EN
    cmd_repeat = 4'd0;
`endif

    // Scenarios 1-4 as one cycle-per-row table: inputs for the cycle, expected outputs in it.
    vec[0]  = mk(1'b1, 6'h05, 8'd3,  6'h00, 6'h00, 1'b0, 1'b1, 1'b0);
    vec[1]  = mk(1'b0, 6'h00, 8'd0,  6'h05, 6'h05, 1'b0, 1'b0, 1'b1);
    vec[2]  = mk(1'b0, 6'h00, 8'd0,  6'h05, 6'h00, 1'b0, 1'b0, 1'b1);
    vec[3]  = mk(1'b0, 6'h00, 8'd0,  6'h05, 6'h00, 1'b0, 1'b0, 1'b1);
    vec[4]  = mk(1'b0, 6'h00, 8'd0,  6'h00, 6'h00, 1'b0, 1'b0, 1'b1);
    vec[5]  = mk(1'b0, 6'h00, 8'd0,  6'h00, 6'h00, 1'b0, 1'b0, 1'b1);
    vec[6]  = mk(1'b0, 6'h00, 8'd0,  6'h00, 6'h00, 1'b1, 1'b1, 1'b0);
    vec[7]  = mk(1'b1, 6'h3f, 8'd0,  6'h00, 6'h00, 1'b0, 1'b1, 1'b0);
    vec[8]  = mk(1'b0, 6'h00, 8'd0,  6'h3f, 6'h3f, 1'b0, 1'b0, 1'b1);
    vec[9]  = mk(1'b0, 6'h00, 8'd0,  6'h00, 6'h00, 1'b0, 1'b0, 1'b1);
    vec[10] = mk(1'b0, 6'h00, 8'd0,  6'h00, 6'h00, 1'b0, 1'b0, 1'b1);
    vec[11] = mk(1'b0, 6'h00, 8'd0,  6'h00, 6'h00, 1'b1, 1'b1, 1'b0);
    vec[12] = mk(1'b1, 6'h00, 8'd9,  6'h00, 6'h00, 1'b0, 1'b1, 1'b0);
    vec[13] = mk(1'b0, 6'h00, 8'd0,  6'h00, 6'h00, 1'b1, 1'b1, 1'b0);
    vec[14] = mk(1'b0, 6'h00, 8'd0,  6'h00, 6'h00, 1'b0, 1'b1, 1'b0);
    vec[15] = mk(1'b1, 6'h03, 8'd2,  6'h00, 6'h00, 1'b0, 1'b1, 1'b0);
    vec[16] = mk(1'b1, 6'h30, 8'd2,  6'h03, 6'h03, 1'b0, 1'b0, 1'b1);
    vec[17] = mk(1'b1, 6'h30, 8'd2,  6'h03, 6'h00, 1'b0, 1'b0, 1'b1);
    vec[18] = mk(1'b1, 6'h30, 8'd2,  6'h00, 6'h00, 1'b0, 1'b0, 1'b1);
    vec[19] = mk(1'b1, 6'h30, 8'd2,  6'h00, 6'h00, 1'b0, 1'b0, 1'b1);
    vec[20] = mk(1'b1, 6'h30, 8'd2,  6'h00, 6'h00, 1'b1, 1'b1, 1'b0);
    vec[21] = mk(1'b0, 6'h00, 8'd0,  6'h30, 6'h30, 1'b0, 1'b0, 1'b1);
    vec[22] = mk(1'b0, 6'h00, 8'd0,  6'h30, 6'h00, 1'b0, 1'b0, 1'b1);
    vec[23] = mk(1'b0, 6'h00, 8'd0,  6'h00, 6'h00, 1'b0, 1'b0, 1'b1);
    vec[24] = mk(1'b0, 6'h00, 8'd0,  6'h00, 6'h00, 1'b0, 1'b0, 1'b1);
    vec[25] = mk(1'b0, 6'h00, 8'd0,  6'h00, 6'h00, 1'b1, 1'b1, 1'b0);

    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 26; i++) begin
      @(negedge clk);
      cmd_valid = vec[i].valid;
      cmd_mask  = vec[i].mask;
      cmd_hold  = vec[i].hold;
      sample($sformatf("table[%0d]", i), vec[i].sv, vec[i].st, vec[i].done, vec[i].ready, vec[i].busy);
    end

    // Scenario 5: async reset in the second high cycle of a hold=10 pulse.
    @(negedge clk);
    cmd_valid = 1'b1; cmd_mask = 6'h2a; cmd_hold = 8'd10;
    sample("rst_accept", 6'h00, 6'h00, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    cmd_valid = 1'b0; cmd_mask = 6'h00; cmd_hold = 8'd0;
    sample("rst_high1", 6'h2a, 6'h2a, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    sample("rst_high2", 6'h2a, 6'h00, 1'b0, 1'b0, 1'b1);
    #1 rst = 1'b1;
    #1 sample("rst_async", 6'h00, 6'h00, 1'b0, 1'b1, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int j = 0; j < 12; j++) begin
      @(negedge clk);
      sample($sformatf("rst_nodone[%0d]", j), 6'h00, 6'h00, 1'b0, 1'b1, 1'b0);
    end
    @(negedge clk);
    cmd_valid = 1'b1; cmd_mask = 6'h01; cmd_hold = 8'd1;
    sample("post_rst_accept", 6'h00, 6'h00, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    cmd_valid = 1'b0; cmd_mask = 6'h00; cmd_hold = 8'd0;
    sample("post_rst_high", 6'h01, 6'h01, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    sample("post_rst_low1", 6'h00, 6'h00, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    sample("post_rst_low2", 6'h00, 6'h00, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    sample("post_rst_done", 6'h00, 6'h00, 1'b1, 1'b1, 1'b0);

`ifdef SVGEN_REPEAT_EN
    // Scenario 6: three 2-cycle pulses separated by 2 low cycles, one done in cycle 13.
    @(negedge clk);
    cmd_valid = 1'b1; cmd_mask = 6'h08; cmd_hold = 8'd2; cmd_repeat = 4'd2;
    sample("rep_accept", 6'h00, 6'h00, 1'b0, 1'b1, 1'b0);
    for (int j = 1; j <= 13; j++) begin
      logic [5:0] e_sv;
      logic [5:0] e_st;
      @(negedge clk);
      cmd_valid = 1'b0; cmd_mask = 6'h00; cmd_hold = 8'd0; cmd_repeat = 4'd0;
      e_sv = (j <= 12 && ((j - 1) % 4) < 2) ? 6'h08 : 6'h00;
      e_st = (j == 1 || j == 5 || j == 9) ? 6'h08 : 6'h00;
      sample($sformatf("rep_cycle[%0d]", j), e_sv, e_st, (j == 13), (j == 13), (j != 13));
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
